// File: rtl/snes_pkg.sv
// Shared definitions for the multi-pad SNES/NES controller reader.
// Contents: frame-sequencer state encoding, standard frame lengths,
// button bit positions within a channel, and a counter-width helper.
package snes_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH_HI = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam int SNES_BITS = 16;
  localparam int NES_BITS  = 8;

  // Bit position of each button inside one channel's BUTTONS slice.
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  // Width of a counter covering 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snes_bit_timer.sv
// Half-period timer for the pad protocol.
// Counts 0..CLK_DIV-1 and wraps; `last` flags the final cycle of each
// half-period. `clear` holds the count at 0 so the first half-period after
// release starts on a clean boundary.
// Ports: clk, rst_n (async active-low), clear (in), last (out).
module snes_bit_timer
  import snes_pkg::*;
#(
  parameter int CLK_DIV = 300
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic last
);

  localparam int W = cnt_width(CLK_DIV);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign last = (cnt_q == W'(CLK_DIV - 1));

  // Next count: hold at zero while cleared, wrap after the last cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snes_multi_reader.sv
// Multi-pad SNES/NES controller reader.
// Drives one shared LATCH/PULSE pair to NUM_CH pads, shifts NUM_BITS bits
// from each pad's DATA line, and presents every pad's buttons together with
// a one-cycle VALID strobe. Frames start on START or on a periodic poll tick.
// Ports: CLOCK, RESET_N (async active-low), ENABLE (periodic polling),
//   START (manual request), DATA[NUM_CH] (active-low serial, async),
//   LATCH, PULSE (idles high), BUTTONS (active-high, channel c at
//   [c*NUM_BITS +: NUM_BITS], bit 0 = first shifted), VALID, BUSY.
// Optional: define SNES_MULTI_EDGE_EN to add PRESSED, the newly-pressed
//   buttons, asserted in the VALID cycle only.
module snes_multi_reader
  import snes_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int NUM_BITS = 16,
  parameter int CLK_DIV  = 300,
  parameter int POLL_DIV = 833333
) (
  input  logic                       CLOCK,
  input  logic                       RESET_N,
  input  logic                       ENABLE,
  input  logic                       START,
  input  logic [NUM_CH-1:0]          DATA,
  output logic                       LATCH,
  output logic                       PULSE,
  output logic [NUM_CH*NUM_BITS-1:0] BUTTONS,
`ifdef SNES_MULTI_EDGE_EN
  output logic [NUM_CH*NUM_BITS-1:0] PRESSED,
`endif
  output logic                       VALID,
  output logic                       BUSY
);

  localparam int IW = cnt_width(NUM_BITS);
  localparam int PW = cnt_width(POLL_DIV);

  state_t                          state_q, state_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic                            half_q, half_d;
  logic                            latch_q, latch_d;
  logic                            pulse_q, pulse_d;
  logic                            valid_q, valid_d;
  logic                            busy_q, busy_d;
  logic [NUM_CH-1:0][NUM_BITS-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0][NUM_BITS-1:0] buttons_q, buttons_d;
  logic [PW-1:0]                   poll_cnt_q, poll_cnt_d;
  logic [NUM_CH-1:0]               sync1_q, sync2_q;
  logic                            poll_tick;
  logic                            tmr_clear;
  logic                            tmr_last;
`ifdef SNES_MULTI_EDGE_EN
  logic [NUM_CH*NUM_BITS-1:0]      pressed_q, pressed_d;
`endif

  assign LATCH   = latch_q;
  assign PULSE   = pulse_q;
  assign VALID   = valid_q;
  assign BUSY    = busy_q;
  assign BUTTONS = buttons_q;
`ifdef SNES_MULTI_EDGE_EN
  assign PRESSED = pressed_q;
`endif

  // Timer runs only while a frame is in progress.
  assign tmr_clear = (state_q == IDLE) || (state_q == DONE);

  snes_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk  (CLOCK),
    .rst_n(RESET_N),
    .clear(tmr_clear),
    .last (tmr_last)
  );

  // Two-flop synchroniser for the asynchronous pad data lines; idle lines
  // are high, so reset to ones (nothing pressed).
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= DATA;
      sync2_q <= sync1_q;
    end
  end

  assign poll_tick = ENABLE && (poll_cnt_q == PW'(POLL_DIV - 1));

  // Poll counter: free-runs while enabled, held at zero otherwise.
  always_comb begin
    poll_cnt_d = poll_cnt_q;
    if (!ENABLE) begin
      poll_cnt_d = '0;
    end else if (poll_tick) begin
      poll_cnt_d = '0;
    end else begin
      poll_cnt_d = poll_cnt_q + PW'(1);
    end
  end

  // Frame sequencer next state; outputs are computed one cycle ahead so
  // they come straight from flops.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    half_d    = half_q;
    latch_d   = latch_q;
    pulse_d   = pulse_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    shadow_d  = shadow_q;
    buttons_d = buttons_q;
`ifdef SNES_MULTI_EDGE_EN
    pressed_d = '0;
`endif
    case (state_q)
      IDLE: begin
        // START and a tick together still give a single frame.
        if (START || poll_tick) begin
          state_d = LATCH_HI;
          latch_d = 1'b1;
          busy_d  = 1'b1;
          half_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      LATCH_HI: begin
        // Latch spans two half-periods; half_q marks the second.
        if (tmr_last && half_q) begin
          state_d = SHIFT_LO;
          latch_d = 1'b0;
          pulse_d = 1'b0;
          idx_d   = '0;
        end else if (tmr_last) begin
          half_d = 1'b1;
        end else begin
          half_d = half_q;
        end
      end
      SHIFT_LO: begin
        if (tmr_last) begin
          for (int c = 0; c < NUM_CH; c++) begin
            shadow_d[c][idx_q] = ~sync2_q[c];
          end
          pulse_d = 1'b1;
          state_d = SHIFT_HI;
        end else begin
          state_d = SHIFT_LO;
        end
      end
      SHIFT_HI: begin
        if (tmr_last && (idx_q == IW'(NUM_BITS - 1))) begin
          state_d   = DONE;
          buttons_d = shadow_q;
          valid_d   = 1'b1;
          busy_d    = 1'b0;
`ifdef SNES_MULTI_EDGE_EN
          pressed_d = shadow_q & ~buttons_q;
`endif
        end else if (tmr_last) begin
          idx_d   = idx_q + IW'(1);
          pulse_d = 1'b0;
          state_d = SHIFT_LO;
        end else begin
          state_d = SHIFT_HI;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        latch_d = 1'b0;
        pulse_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, output and data registers.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      half_q     <= 1'b0;
      latch_q    <= 1'b0;
      pulse_q    <= 1'b1;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      shadow_q   <= '0;
      buttons_q  <= '0;
      poll_cnt_q <= '0;
`ifdef SNES_MULTI_EDGE_EN
      pressed_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      half_q     <= half_d;
      latch_q    <= latch_d;
      pulse_q    <= pulse_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      shadow_q   <= shadow_d;
      buttons_q  <= buttons_d;
      poll_cnt_q <= poll_cnt_d;
`ifdef SNES_MULTI_EDGE_EN
      pressed_q  <= pressed_d;
`endif
    end
  end

endmodule

// File: tb/tb_snes_multi_reader.sv
`timescale 1ns/1ps
module tb_snes_multi_reader;

  localparam int NUM_CH    = 2;
  localparam int NUM_BITS  = 16;
  localparam int CLK_DIV   = 4;
  localparam int POLL_DIV  = 200;
  localparam int W         = NUM_CH * NUM_BITS;
  localparam int FRAME     = (2 + 2 * NUM_BITS) * CLK_DIV;
  localparam int NES_N     = 8;
  localparam int NES_FRAME = (2 + 2 * NES_N) * CLK_DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, enable, start;
  logic [NUM_CH-1:0] data;
  logic              latch, pulse, valid, busy;
  logic [W-1:0]      buttons;
  logic              nes_start;
  logic [0:0]        nes_data;
  logic              nes_latch, nes_pulse, nes_valid, nes_busy;
  logic [NES_N-1:0]  nes_buttons;
`ifdef SNES_MULTI_EDGE_EN
  logic [W-1:0]      pressed;
  logic [NES_N-1:0]  nes_pressed;
`endif

  snes_multi_reader #(.NUM_CH(NUM_CH), .NUM_BITS(NUM_BITS), .CLK_DIV(CLK_DIV), .POLL_DIV(POLL_DIV)) dut (
    .CLOCK(clk), .RESET_N(rst_n), .ENABLE(enable), .START(start), .DATA(data),
    .LATCH(latch), .PULSE(pulse), .BUTTONS(buttons),
`ifdef SNES_MULTI_EDGE_EN
    .PRESSED(pressed),
`endif
    .VALID(valid), .BUSY(busy));

  snes_multi_reader #(.NUM_CH(1), .NUM_BITS(NES_N), .CLK_DIV(CLK_DIV), .POLL_DIV(POLL_DIV)) dut_nes (
    .CLOCK(clk), .RESET_N(rst_n), .ENABLE(1'b0), .START(nes_start), .DATA(nes_data),
    .LATCH(nes_latch), .PULSE(nes_pulse), .BUTTONS(nes_buttons),
`ifdef SNES_MULTI_EDGE_EN
    .PRESSED(nes_pressed),
`endif
    .VALID(nes_valid), .BUSY(nes_busy));

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  // Pad models: present ~pattern[k]; k restarts on LATCH, advances on PULSE rise.
  logic [NUM_BITS-1:0] pat [NUM_CH];
  logic [NES_N-1:0]    nes_pat;
  int k = 0;
  int nk = 0;
  always @(posedge latch or posedge pulse) begin
    if (latch) k = 0;
    else k = k + 1;
  end
  always @(posedge nes_latch or posedge nes_pulse) begin
    if (nes_latch) nk = 0;
    else nk = nk + 1;
  end
  always @* begin
    for (int c = 0; c < NUM_CH; c++) data[c] = (k < NUM_BITS) ? ~pat[c][k] : 1'b0;
    nes_data[0] = (nk < NES_N) ? ~nes_pat[nk] : 1'b0;
  end

  // Scoreboard queues: expected BUTTONS per frame, pushed by the stimulus.
  logic [W-1:0]     exp_q[$];
  logic [NES_N-1:0] nes_exp_q[$];

  // Main monitor.
  int cyc = 0;
  int rise_cyc, latch_len, pulse_cnt, low_len;
  logic prev_latch = 1'b0, prev_pulse = 1'b1;
  logic [W-1:0] last_model = '0;
  logic [W-1:0] e;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      last_model = '0;
      prev_latch = latch;
      prev_pulse = pulse;
    end else begin
      if (latch && !prev_latch) begin
        rise_cyc = cyc; latch_len = 0; pulse_cnt = 0;
      end
      if (latch) latch_len++;
      if (!pulse) begin
        if (prev_pulse) begin pulse_cnt++; low_len = 1; end
        else low_len++;
      end
      if (pulse && !prev_pulse) check("pulse_low_len", low_len, CLK_DIV);
      if (valid) begin
        check("valid_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("buttons", buttons, e);
          check("frame_len", cyc - rise_cyc, FRAME);
          check("pulse_count", pulse_cnt, NUM_BITS);
          check("latch_len", latch_len, 2 * CLK_DIV);
          check("busy_at_valid", busy, 1'b0);
`ifdef SNES_MULTI_EDGE_EN
          check("pressed_valid", pressed, e & ~last_model);
`endif
          last_model = e;
        end
      end else begin
`ifdef SNES_MULTI_EDGE_EN
        check("pressed_idle", pressed, '0);
`endif
      end
      prev_latch = latch;
      prev_pulse = pulse;
    end
  end

  // NES monitor.
  int n_rise, n_pulses;
  logic n_prev_latch = 1'b0, n_prev_pulse = 1'b1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (nes_latch && !n_prev_latch) begin n_rise = cyc; n_pulses = 0; end
      if (!nes_pulse && n_prev_pulse) n_pulses++;
      if (nes_valid) begin
        check("nes_valid_expected", nes_exp_q.size() != 0, 1'b1);
        if (nes_exp_q.size() != 0) begin
          check("nes_buttons", nes_buttons, nes_exp_q.pop_front());
          check("nes_frame_len", cyc - n_rise, NES_FRAME);
          check("nes_pulse_count", n_pulses, NES_N);
        end
      end
    end
    n_prev_latch = nes_latch;
    n_prev_pulse = nes_pulse;
  end

  task automatic wait_valid(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!valid && n < 400);
    check(name, valid, 1'b1);
  endtask

  task automatic main_frame(input logic [NUM_BITS-1:0] p0, input logic [NUM_BITS-1:0] p1);
    @(posedge clk); #1;
    pat[0] = p0; pat[1] = p1;
    exp_q.push_back({p1, p0});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid("frame_valid_seen");
    repeat (3) @(posedge clk);
  endtask

  task automatic nes_frame(input logic [NES_N-1:0] p);
    int n = 0;
    @(posedge clk); #1;
    nes_pat = p;
    nes_exp_q.push_back(p);
    nes_start = 1'b1;
    @(posedge clk); #1;
    nes_start = 1'b0;
    do begin @(negedge clk); n++; end while (!nes_valid && n < 300);
    check("nes_valid_seen", nes_valid, 1'b1);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_latch"}, latch, 1'b0);
    check({tag, "_pulse"}, pulse, 1'b1);
    check({tag, "_buttons"}, buttons, '0);
    check({tag, "_valid"}, valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int last_rise, n, falls;
    rst_n = 1'b0; enable = 1'b0; start = 1'b0; nes_start = 1'b0;
    pat[0] = '0; pat[1] = '0; nes_pat = '0;
    repeat (4) @(posedge clk); #1;
    check_reset_outputs("reset");
    check("nes_reset_pulse", nes_pulse, 1'b1);
    check("nes_reset_buttons", nes_buttons, '0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed SNES frame, then hold check.
    main_frame(16'h0F5A, 16'h8001);
    repeat (20) @(posedge clk); #1;
    check("buttons_hold", buttons, 32'h80010F5A);

    // Randomized frames.
    for (int i = 0; i < 4; i++) main_frame(16'($urandom), 16'($urandom));

    // Newly-pressed sequence.
    main_frame(16'h0001, 16'h0000);
    main_frame(16'h0003, 16'h0000);

    // NES length frames.
    nes_frame(8'hA5);
    nes_frame(8'($urandom));
    nes_frame(8'($urandom));

    // Periodic polling; a START during the second frame must not add a frame.
    pat[0] = 16'($urandom); pat[1] = 16'($urandom);
    exp_q.push_back({pat[1], pat[0]});
    @(posedge clk); #1;
    enable = 1'b1;
    last_rise = 0;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!latch && n < 400);
      check("poll_latch_seen", latch, 1'b1);
      if (i > 0) check("poll_period", cyc - last_rise, POLL_DIV);
      last_rise = cyc;
      if (i == 1) begin
        repeat (10) @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      wait_valid("poll_valid_seen");
      if (i < 2) begin
        pat[0] = 16'($urandom); pat[1] = 16'($urandom);
        exp_q.push_back({pat[1], pat[0]});
      end else begin
        enable = 1'b0;
      end
    end
    repeat (300) @(posedge clk);
    check("no_frame_after_disable", exp_q.size(), 0);

    // Reset during SHIFT_LO of bit 5 aborts the frame.
    @(posedge clk); #1;
    pat[0] = 16'($urandom); pat[1] = 16'($urandom);
    exp_q.push_back({pat[1], pat[0]});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    falls = 0; n = 0;
    do begin
      @(negedge clk); n++;
      if (!pulse && prev_pulse) falls++;
    end while (falls < 6 && n < 400);
    check("reached_bit5", falls, 6);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check_reset_outputs("midframe_reset");
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    main_frame(16'($urandom), 16'($urandom));
    main_frame(16'h0F5A, 16'h8001);

    repeat (5) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("nes_queue_drained", nes_exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/snes_multi_reader.md
Name: snes_multi_reader

Overview:
- Parametrised successor to the single-pad SNES controller reader.
- Drives a shared LATCH/PULSE pair to NUM_CH pads, each with its own serial DATA line, in SNES (16-bit) or NES (8-bit) frame length.
- Polls periodically or on demand, then presents all pads' buttons atomically with a VALID strobe.
- Sits between the pad connectors and the CPU joypad-register logic.

Parameters:
- NUM_CH, 2, number of pads sharing LATCH/PULSE (1..4).
- NUM_BITS, 16, bits shifted per frame (16 = SNES, 8 = NES).
- CLK_DIV, 300, CLOCK cycles per protocol half-period (6 us at 50 MHz); minimum 4.
- POLL_DIV, 833333, CLOCK cycles between automatic poll requests (60 Hz at 50 MHz).

Ports:
- CLOCK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  enables periodic polling.
- START  in  1  one-cycle manual frame request.
- DATA  in  NUM_CH  serial data from pads; active-low (0 = pressed); asynchronous.
- LATCH  out  1  latch pulse to all pads.
- PULSE  out  1  shift clock to all pads; idles high.
- BUTTONS  out  NUM_CH*NUM_BITS  active-high buttons; channel c occupies [c*NUM_BITS +: NUM_BITS]; bit 0 = first bit shifted (B).
- VALID  out  1  one-cycle strobe when BUTTONS updates.
- BUSY  out  1  high while a frame is in progress.

Behaviour:
- Reset values: LATCH=0, PULSE=1, BUTTONS=0, VALID=0, BUSY=0, state IDLE, poll counter 0. Reset mid-frame aborts immediately; BUTTONS is not updated.
- Input synchroniser: each DATA bit passes through a 2-flop synchroniser before sampling.
- Half-period timer: counts 0..CLK_DIV-1; each state below lasts a whole number of half-periods.
- IDLE:
  - A request is START=1, or a poll tick.
  - On a request, go to LATCH_HI the next cycle: LATCH=1, BUSY=1, timer cleared.
- LATCH_HI: lasts 2 half-periods, then LATCH=0 and go to SHIFT_LO with bit index 0.
- SHIFT_LO:
  - PULSE=0 for 1 half-period.
  - On the last cycle, sample synchronised DATA for bit index i of every channel into per-channel shadow registers, inverted (pressed -> 1).
- SHIFT_HI:
  - PULSE=1 for 1 half-period; the pad shifts its next bit on this rising edge.
  - On the last cycle, if i==NUM_BITS-1 go to DONE, else i++ and go to SHIFT_LO.
- DONE (1 cycle): copy all shadow registers to BUTTONS together, VALID=1, BUSY=0, return to IDLE.
- Frame length: LATCH rising to VALID = (2+2*NUM_BITS)*CLK_DIV cycles exactly.
- Poll counter:
  - While ENABLE=1, counts 0..POLL_DIV-1 and wraps; the poll tick fires on the wrap.
  - While ENABLE=0, the counter is held at 0.
- Dropped requests:
  - A tick arriving while BUSY is dropped, not queued.
  - START while BUSY is ignored.
  - START and tick in the same cycle produce one frame.
- ENABLE deasserted mid-frame: the frame completes normally.
- BUTTONS holds its value between frames.
- Bit-index counter is clog2(NUM_BITS) wide.

Optional Feature:
- Macro: SNES_MULTI_EDGE_EN.
- With the macro defined:
  - Extra output PRESSED (out, NUM_CH*NUM_BITS).
  - PRESSED = new BUTTONS & ~old BUTTONS, asserted in the VALID cycle only; 0 otherwise and at reset.
- Without the macro: no PRESSED port and no previous-value register.

Decomposition:
- Package snes_pkg:
  - State enum {IDLE, LATCH_HI, SHIFT_LO, SHIFT_HI, DONE}.
  - Constants SNES_BITS=16, NES_BITS=8.
  - Button indices B=0, Y=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7, A=8, X=9, L=10, R=11.
- Sub-module snes_bit_timer: half-period counter with clear input and last-cycle flag, parametrised by CLK_DIV; instanced once.

Test Plan:
(Bench pad model: presents ~pattern[k] on DATA, k reset to 0 on LATCH high and incremented on each PULSE rising edge.)
- Reset: hold RESET_N=0 -> LATCH=0, PULSE=1, BUTTONS=0, VALID=0, BUSY=0.
- Single frame, CLK_DIV=4, NUM_BITS=16, NUM_CH=2, pad patterns 16'h0F5A / 16'h8001, START pulse:
  - LATCH high 8 cycles, then 16 PULSE lows of 4 cycles each.
  - VALID exactly 136 cycles after LATCH rises.
  - BUTTONS = 32'h80010F5A.
- NES mode, NUM_BITS=8, pattern 8'hA5 on ch0 -> 8 pulses, BUTTONS[7:0]=8'hA5, VALID at 72 cycles.
- Polling: ENABLE=1, POLL_DIV=200 -> LATCH rises every 200 cycles; START pulsed during BUSY creates no extra frame.
- Reset mid-frame: RESET_N=0 during SHIFT_LO of bit 5 -> outputs immediately at reset values; the next START gives a full, correct frame.
- SNES_MULTI_EDGE_EN: frames with pattern 16'h0001 then 16'h0003 -> PRESSED[15:0]=16'h0002 only in the second VALID cycle, otherwise 0.
